mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 96 +++++++++
 tb/tb_mem_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (fetch/data) arbiter onto one handshaked memory port.
//   clk, resetn (async, active-low)
//   fetch side : inst_req, inst_addr -> inst_rdata, i_stall
//   data side  : data_req, data_wr, data_wstrb, data_addr, data_wdata -> data_rdata, d_stall
//   memory side: mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata <- mem_addr_ok, mem_data_ok, mem_rdata
//   ARB_ROUND_ROBIN_EN: on simultaneous requests grant the side opposite the last grant;
//   undefined: data side always wins a tie.
module mem_arbiter (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  output logic        i_stall,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        d_stall,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;
  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;
  logic [1:0]  r_state;
  logic        r_owner;
  logic        r_last;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_wr;
  logic [31:0] r_inst_rdata;
  logic [31:0] r_data_rdata;
  logic        w_grant_data;
  logic        w_done;
`ifdef ARB_ROUND_ROBIN_EN
  assign w_grant_data = data_req & (~inst_req | (r_last == OWN_INST));
`else
  assign w_grant_data = data_req;
`endif
  // data_ok only counts once the address phase has been (or is being) accepted
  assign w_done = ((r_state == S_ADDR) & mem_addr_ok & mem_data_ok) |
                  ((r_state == S_WAIT) & mem_data_ok);
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_owner      <= OWN_INST;
      r_last       <= OWN_INST;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_wr         <= 1'b0;
      r_inst_rdata <= '0;
      r_data_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (inst_req | data_req) begin
          r_state <= S_ADDR;
          r_owner <= w_grant_data;
          r_last  <= w_grant_data;
          r_addr  <= w_grant_data ? data_addr : inst_addr;
          r_wdata <= w_grant_data ? data_wdata : 32'h0;
          r_wstrb <= w_grant_data ? data_wstrb : 4'h0;
          r_wr    <= w_grant_data & data_wr;
        end
        S_ADDR: if (mem_addr_ok) r_state <= mem_data_ok ? S_RESP : S_WAIT;
        S_WAIT: if (mem_data_ok) r_state <= S_RESP;
        default: r_state <= S_IDLE;
      endcase
      if (w_done && r_owner == OWN_INST) r_inst_rdata <= mem_rdata;
      if (w_done && r_owner == OWN_DATA && !r_wr) r_data_rdata <= mem_rdata;
    end
  end
  assign mem_req    = (r_state == S_ADDR);
  assign mem_wr     = r_wr;
  assign mem_wstrb  = r_wstrb;
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;
  assign inst_rdata = r_inst_rdata;
  assign data_rdata = r_data_rdata;
  // stalls are forced low during reset so the pipeline is not held by an abandoned transaction
  assign i_stall = resetn & inst_req & ~((r_state == S_RESP) & (r_owner == OWN_INST));
  assign d_stall = resetn & data_req & ~((r_state == S_RESP) & (r_owner == OWN_DATA));
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a randomized memory responder.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        inst_req = 1'b0;
  logic [31:0] inst_addr = '0;
  logic [31:0] inst_rdata;
  logic        i_stall;
  logic        data_req = 1'b0;
  logic        data_wr = 1'b0;
  logic [3:0]  data_wstrb = '0;
  logic [31:0] data_addr = '0;
  logic [31:0] data_wdata = '0;
  logic [31:0] data_rdata;
  logic        d_stall;
  logic        mem_req;
  logic        mem_wr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;
  always #5 clk = ~clk;
  mem_arbiter dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .i_stall(i_stall),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .d_stall(d_stall),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .mem_rdata(mem_rdata)
  );
  int errors = 0;
  int checks = 0;
  logic [31:0] iq[$];
  logic [31:0] dq[$];
  logic        glog[$];
  logic [31:0] last_load = '0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic [31:0] memv(input logic [31:0] a);
    return (a == 32'h0000_0040) ? 32'h2402_0005 : ((a * 32'h9E37_79B1) ^ 32'h1357_9BDF);
  endfunction
  // memory responder: fixed or random address/data delays, optional hold and spurious data_ok
  int a_fix = 0;
  int d_fix = 0;
  int acnt = 0;
  int dcnt = 0;
  int ph = 0;
  bit hold = 1'b0;
  bit spur = 1'b0;
  logic [31:0] cur = '0;
  initial begin
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_addr_ok = 1'b0;
      mem_data_ok = 1'b0;
      mem_rdata = $urandom;
      if (!resetn) ph = 0;
      else if (spur) begin
        mem_data_ok = 1'b1;
        spur = 1'b0;
      end else begin
        if (ph == 0 && mem_req) begin
          acnt = (a_fix >= 0) ? a_fix : int'($urandom_range(0, 3));
          ph = 2;
        end
        if (ph == 2) begin
          if (acnt == 0) begin
            mem_addr_ok = 1'b1;
            cur = mem_addr;
            if (d_fix == -2 || (d_fix == -1 && $urandom_range(0, 3) == 0)) begin
              mem_data_ok = 1'b1;
              mem_rdata = memv(cur);
              ph = 0;
            end else begin
              ph = 1;
              dcnt = (d_fix >= 0) ? d_fix : int'($urandom_range(0, 3));
            end
          end else acnt--;
        end else if (ph == 1) begin
          if (!hold) begin
            if (dcnt == 0) begin
              mem_data_ok = 1'b1;
              mem_rdata = memv(cur);
              ph = 0;
            end else dcnt--;
          end
        end else if ($urandom_range(0, 7) == 0) mem_data_ok = 1'b1;
      end
    end
  end
  // monitor: arbitration and handshake rules, stalls and read data from the scoreboard queues
  bit snap_i = 0, snap_d = 0, txn = 0, acc = 0, done_i = 0, done_d = 0, tb_last = 0;
  logic        ex_own = 0, ex_wr = 0;
  logic [3:0]  ex_strb = '0;
  logic [31:0] ex_addr = '0, ex_wdata = '0;
  int acyc = 0, last_acyc = 0;
  always @(negedge clk) begin
    if (!resetn) begin
      chk("rst_i_stall", {31'b0, i_stall}, 32'd0);
      chk("rst_d_stall", {31'b0, d_stall}, 32'd0);
      txn = 0; acc = 0; done_i = 0; done_d = 0; tb_last = 0; snap_i = 0; snap_d = 0;
    end else begin
      chk("i_stall", {31'b0, i_stall}, {31'b0, inst_req & ~done_i});
      chk("d_stall", {31'b0, d_stall}, {31'b0, data_req & ~done_d});
      if (inst_req && done_i) begin
        if (iq.size() == 0) chk("inst_unexpected", 32'd1, 32'd0);
        else chk("inst_rdata", inst_rdata, iq.pop_front());
      end
      if (data_req && done_d) begin
        if (dq.size() == 0) chk("data_unexpected", 32'd1, 32'd0);
        else chk("data_rdata", data_rdata, dq.pop_front());
      end
      done_i = 0;
      done_d = 0;
      if (mem_req && !txn) begin
        if (!snap_i && !snap_d) chk("grant_no_req", 32'd1, 32'd0);
`ifdef ARB_ROUND_ROBIN_EN
        ex_own = snap_d && (!snap_i || !tb_last);
`else
        ex_own = snap_d;
`endif
        tb_last = ex_own;
        glog.push_back(ex_own);
        ex_addr = ex_own ? data_addr : inst_addr;
        ex_wr = ex_own & data_wr;
        ex_strb = ex_own ? data_wstrb : 4'h0;
        ex_wdata = data_wdata;
        txn = 1; acc = 0; acyc = 0;
      end
      if (txn && !acc) begin
        chk("mem_req", {31'b0, mem_req}, 32'd1);
        chk("mem_addr", mem_addr, ex_addr);
        chk("mem_wr", {31'b0, mem_wr}, {31'b0, ex_wr});
        chk("mem_wstrb", {28'b0, mem_wstrb}, {28'b0, ex_strb});
        if (ex_own) chk("mem_wdata", mem_wdata, ex_wdata);
        acyc++;
      end else chk("mem_req_idle", {31'b0, mem_req}, 32'd0);
      if (txn) begin
        if (!acc && mem_addr_ok) begin
          acc = 1;
          last_acyc = acyc;
        end
        if (acc && mem_data_ok) begin
          if (ex_own) done_d = 1;
          else done_i = 1;
          txn = 0;
        end
      end
      snap_i = inst_req;
      snap_d = data_req;
    end
  end
  task automatic do_inst(input logic [31:0] a, output int lat);
    inst_req = 1'b1;
    inst_addr = a;
    iq.push_back(memv(a));
    lat = 0;
    forever begin
      @(negedge clk);
      if (!i_stall) break;
      lat++;
      if (lat > 300) begin
        chk("inst_timeout", 32'd1, 32'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
    inst_req = 1'b0;
    inst_addr = $urandom;
  endtask
  task automatic do_data(input logic wr, input logic [3:0] st, input logic [31:0] a,
                         input logic [31:0] wd, output int lat);
    data_req = 1'b1;
    data_wr = wr;
    data_wstrb = st;
    data_addr = a;
    data_wdata = wd;
    if (!wr) last_load = memv(a);
    dq.push_back(last_load);
    lat = 0;
    forever begin
      @(negedge clk);
      if (!d_stall) break;
      lat++;
      if (lat > 300) begin
        chk("data_timeout", 32'd1, 32'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
    data_req = 1'b0;
    data_wr = $urandom_range(0, 1);
    data_addr = $urandom;
    data_wdata = $urandom;
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int lat, lat2, g;
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    @(negedge clk);
    chk("reset_inst_rdata", inst_rdata, 32'd0);
    chk("reset_data_rdata", data_rdata, 32'd0);
    @(posedge clk);
    #1;
    a_fix = 0; d_fix = 0;
    do_inst(32'h0000_0040, lat);
    chk("fetch_latency", lat, 32'd3);
    chk("fetch_word", inst_rdata, 32'h2402_0005);
    d_fix = -2;
    do_data(1'b0, 4'hF, 32'h0000_2000, 32'h0, lat);
    chk("combined_ok_latency", lat, 32'd2);
    a_fix = 3; d_fix = 0;
    do_data(1'b1, 4'h3, 32'h1000_0000, 32'hDEAD_BEEF, lat);
    chk("store_addr_cycles", last_acyc, 32'd4);
    a_fix = 0;
    glog.delete();
    fork
      do_data(1'b0, 4'hF, 32'h0000_3000, 32'h0, lat);
      do_inst(32'h0000_0100, lat2);
    join
`ifndef ARB_ROUND_ROBIN_EN
    chk("tie_first_data", {31'b0, glog[0]}, 32'd1);
    chk("tie_second_inst", {31'b0, glog[1]}, 32'd0);
`endif
    hold = 1'b1;
    inst_req = 1'b1;
    inst_addr = 32'h0000_0080;
    repeat (4) @(posedge clk);
    #1;
    resetn = 1'b0;
    @(negedge clk);
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_inst_rdata", inst_rdata, 32'd0);
    chk("rst_data_rdata", data_rdata, 32'd0);
    @(posedge clk);
    #1;
    inst_req = 1'b0;
    resetn = 1'b1;
    last_load = '0;
    hold = 1'b0;
    spur = 1'b1;
    repeat (4) @(negedge clk);
    chk("late_ok_inst_rdata", inst_rdata, 32'd0);
    chk("late_ok_mem_req", {31'b0, mem_req}, 32'd0);
    @(posedge clk);
    #1;
    a_fix = -1; d_fix = -1;
    fork
      repeat (60) begin
        g = $urandom_range(0, 3);
        if (g > 0) begin
          repeat (g) @(posedge clk);
          #1;
        end
        do_inst($urandom & 32'hFFFF_FFFC, lat);
      end
      repeat (60) begin
        int gd, ld;
        gd = $urandom_range(0, 3);
        if (gd > 0) begin
          repeat (gd) @(posedge clk);
          #1;
        end
        do_data(1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)), $urandom & 32'hFFFF_FFFC,
                $urandom, ld);
      end
    join
    repeat (5) @(posedge clk);
    chk("iq_drained", iq.size(), 32'd0);
    chk("dq_drained", dq.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
